// File: rtl/pea_pkg.sv
// ----------------------------------------------------------------------------
// pea_pkg : shared constants and types for the streaming PE array.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pea_pkg;

   localparam int N_BITS          = 32;
   localparam int COLLECTOR_DEPTH = 4;

   typedef enum logic [1:0] {
      COL_IDLE  = 2'd0,
      COL_RUN   = 2'd1,
      COL_DRAIN = 2'd2,
      COL_DONE  = 2'd3
   } collector_state_t;

endpackage

`default_nettype wire

// File: rtl/s_res_fifo.sv
// ----------------------------------------------------------------------------
// s_res_fifo : synchronous FIFO with flush and fill count, no fall-through.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module s_res_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     fill_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [FW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && (count != FW'(DEPTH));
   assign do_pop  = pop_i && (count != '0);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + FW'(1);
            2'b01:   count <= count - FW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wdata_i;
   end

   assign valid_o = (count != '0);
   assign rdata_o = valid_o ? mem[rd_ptr] : '0;
   assign fill_o  = count;

endmodule

`default_nettype wire

// File: rtl/s_pe_res_collector.sv
// ----------------------------------------------------------------------------
// s_pe_res_collector : buffers PE array results, drives array backpressure,
// tags the final word and pulses completion. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module s_pe_res_collector
   import pea_pkg::*;
#(
   parameter int N_BITS = pea_pkg::N_BITS,
   parameter int DEPTH  = pea_pkg::COLLECTOR_DEPTH,
   parameter int LEN_W  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       abort_i,
   input  logic [LEN_W-1:0]           cfg_len_i,
   input  logic [N_BITS-1:0]          pe_res_i,
   input  logic                       pe_valid_i,
   output logic                       pea_ready_o,
   output logic [N_BITS-1:0]          out_data_o,
   output logic                       out_valid_o,
   output logic                       out_last_o,
   input  logic                       out_ready_i,
   output logic                       done_o,
   output logic                       busy_o,
   output logic [$clog2(DEPTH):0]     fill_o
);

   localparam int FW = $clog2(DEPTH) + 1;

   collector_state_t state_q;
   collector_state_t state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] acc_cnt;
   logic [LEN_W-1:0] acc_nxt;
   logic             push;
   logic             pop;
   logic             last_push;
   logic [N_BITS:0]  head;

   assign acc_nxt   = acc_cnt + LEN_W'(1);
   assign push      = pe_valid_i && pea_ready_o && !abort_i;
   assign last_push = push && (acc_nxt == len_q);
   assign pop       = out_valid_o && out_ready_i && !abort_i;

   s_res_fifo #(
      .WIDTH (N_BITS + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (abort_i),
      .push_i  (push),
      .wdata_i ({last_push, pe_res_i}),
      .pop_i   (pop),
      .rdata_o (head),
      .valid_o (out_valid_o),
      .fill_o  (fill_o)
   );

   assign out_data_o = head[N_BITS-1:0];
   assign out_last_o = head[N_BITS];

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= COL_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         len_q   <= '0;
         acc_cnt <= '0;
      end else if (state_q == COL_IDLE && start_i && !abort_i) begin
         len_q   <= cfg_len_i;
         acc_cnt <= '0;
      end else if (push) begin
         acc_cnt <= acc_nxt;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = COL_IDLE;
      end else begin
         case (state_q)
            COL_IDLE:  if (start_i) state_d = (cfg_len_i != '0) ? COL_RUN : COL_DONE;
            COL_RUN:   if (last_push) state_d = COL_DRAIN;
            COL_DRAIN: if (pop && out_last_o) state_d = COL_DONE;
            COL_DONE:  state_d = COL_IDLE;
            default:   state_d = COL_IDLE;
         endcase
      end
   end

   // Ready looks only at registered occupancy, keeping out_ready_i off this path.
   always_comb begin
      pea_ready_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         COL_RUN: begin
            pea_ready_o = (fill_o < FW'(DEPTH));
            busy_o      = 1'b1;
         end
         COL_DRAIN: busy_o = 1'b1;
         COL_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_s_pe_res_collector.sv
// ----------------------------------------------------------------------------
// tb_s_pe_res_collector : table, directed and random checks of the collector.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_s_pe_res_collector;

   localparam int NB = 32;
   localparam int D  = 4;
   localparam int LW = 16;
   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

   logic          clk = 1'b0;
   logic          rst, start, abort, pe_valid, out_ready;
   logic [LW-1:0] cfg_len;
   logic [NB-1:0] pe_res;
   logic          pea_ready_o, out_valid_o, out_last_o, done_o, busy_o;
   logic [NB-1:0] out_data_o;
   logic [2:0]    fill_o;

   always #5 clk = ~clk;

   s_pe_res_collector #(.N_BITS(NB), .DEPTH(D), .LEN_W(LW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .abort_i     (abort),
      .cfg_len_i   (cfg_len),
      .pe_res_i    (pe_res),
      .pe_valid_i  (pe_valid),
      .pea_ready_o (pea_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_last_o  (out_last_o),
      .out_ready_i (out_ready),
      .done_o      (done_o),
      .busy_o      (busy_o),
      .fill_o      (fill_o)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO contents as a queue plus transfer phase.
   typedef struct { logic last; logic [NB-1:0] data; } ent_t;
   ent_t          mq[$];
   int            ph = P_IDLE;
   int            m_len = 0, m_acc = 0;
   bit            m_push = 0;
   int            done_seen = 0;
   logic [NB-1:0] got[$];

   task automatic tick();
      chk("pea_ready", {63'd0, pea_ready_o}, {63'd0, (ph == P_RUN && mq.size() < D)});
      chk("out_valid", {63'd0, out_valid_o}, {63'd0, (mq.size() != 0)});
      if (mq.size() != 0) begin
         chk("out_data", {32'd0, out_data_o}, {32'd0, mq[0].data});
         chk("out_last", {63'd0, out_last_o}, {63'd0, mq[0].last});
      end
      chk("fill", {61'd0, fill_o}, 64'(mq.size()));
      chk("busy", {63'd0, busy_o}, {63'd0, (ph == P_RUN || ph == P_DRAIN)});
      chk("done", {63'd0, done_o}, {63'd0, (ph == P_DONE)});
      if (done_o) done_seen++;
      if (out_valid_o && out_ready && !abort && !rst) got.push_back(out_data_o);
      m_push = 0;
      if (rst || abort) begin
         mq.delete();
         ph = P_IDLE;
      end else begin
         bit   popped_last;
         bit   m_pop;
         int   nph;
         ent_t e;
         nph = ph;
         popped_last = 0;
         m_pop  = (mq.size() > 0) && out_ready;
         m_push = (ph == P_RUN) && (mq.size() < D) && pe_valid;
         if (m_pop) begin
            popped_last = mq[0].last;
            void'(mq.pop_front());
         end
         if (m_push) begin
            m_acc++;
            e.last = (m_acc == m_len);
            e.data = pe_res;
            mq.push_back(e);
            if (e.last) nph = P_DRAIN;
         end
         case (ph)
            P_IDLE: if (start) begin
               if (cfg_len != 0) begin
                  nph = P_RUN; m_len = int'(cfg_len); m_acc = 0;
               end else nph = P_DONE;
            end
            P_DRAIN: if (popped_last) nph = P_DONE;
            P_DONE:  nph = P_IDLE;
            default: ;
         endcase
         ph = nph;
      end
      @(posedge clk); #1;
   endtask

   // Directed PE source: steps through consecutive words up to lastw.
   task automatic tick_feed(input logic [NB-1:0] lastw);
      tick();
      if (m_push) begin
         if (pe_res == lastw) pe_valid = 0;
         else pe_res = pe_res + 1;
      end
   endtask

   task automatic begin_xfer(input int len, input logic [NB-1:0] first, input bit ordy);
      cfg_len = LW'(len); start = 1; pe_res = first; pe_valid = 1; out_ready = ordy;
      tick();
      start = 0;
   endtask

   task automatic run_to_done(input string name, input logic [NB-1:0] lastw, input int budget);
      int d0;
      int n;
      d0 = done_seen;
      n = 0;
      while (done_seen == d0 && n < budget) begin
         tick_feed(lastw);
         n++;
      end
      chk({name, "_done_in_budget"}, 64'(done_seen - d0), 64'd1);
   endtask

   task automatic check_got(input string name, input logic [NB-1:0] base, input int n);
      chk({name, "_count"}, 64'(got.size()), 64'(n));
      for (int i = 0; i < n && i < got.size(); i++)
         chk({name, "_word"}, {32'd0, got[i]}, {32'd0, base + NB'(i)});
   endtask

   typedef struct {
      bit st; int len; bit pv; logic [NB-1:0] pd; bit ordy;
      bit rdy; bit vld; logic [NB-1:0] dat; bit lst; bit dn; bit bsy; int fl;
   } vec_t;
   vec_t tbl[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          st len pv pd     ordy rdy vld dat    lst dn bsy fl
      tbl[0] = '{1, 4, 0, 32'h0,  1,   1,  0,  32'h0,  0, 0, 1, 0};
      tbl[1] = '{0, 0, 1, 32'h11, 1,   1,  1,  32'h11, 0, 0, 1, 1};
      tbl[2] = '{0, 0, 1, 32'h12, 1,   1,  1,  32'h12, 0, 0, 1, 1};
      tbl[3] = '{0, 0, 1, 32'h13, 1,   1,  1,  32'h13, 0, 0, 1, 1};
      tbl[4] = '{0, 0, 1, 32'h14, 1,   0,  1,  32'h14, 1, 0, 1, 1};
      tbl[5] = '{0, 0, 0, 32'h0,  1,   0,  0,  32'h0,  0, 1, 0, 0};
      tbl[6] = '{0, 0, 0, 32'h0,  1,   0,  0,  32'h0,  0, 0, 0, 0};
      tbl[7] = '{1, 0, 0, 32'h0,  1,   0,  0,  32'h0,  0, 1, 0, 0};
      tbl[8] = '{0, 0, 0, 32'h0,  1,   0,  0,  32'h0,  0, 0, 0, 0};

      rst = 1; start = 0; abort = 0; pe_valid = 0; out_ready = 0; cfg_len = '0; pe_res = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      chk("rst_ready", {63'd0, pea_ready_o}, 64'd0);
      chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
      chk("rst_data",  {32'd0, out_data_o}, 64'd0);
      chk("rst_fill",  {61'd0, fill_o}, 64'd0);
      chk("rst_done_busy", {62'd0, done_o, busy_o}, 64'd0);

      for (int i = 0; i < 9; i++) begin
         start = tbl[i].st; cfg_len = LW'(tbl[i].len); pe_valid = tbl[i].pv;
         pe_res = tbl[i].pd; out_ready = tbl[i].ordy;
         tick();
         chk("tbl_ready", {63'd0, pea_ready_o}, {63'd0, tbl[i].rdy});
         chk("tbl_valid", {63'd0, out_valid_o}, {63'd0, tbl[i].vld});
         if (tbl[i].vld) begin
            chk("tbl_data", {32'd0, out_data_o}, {32'd0, tbl[i].dat});
            chk("tbl_last", {63'd0, out_last_o}, {63'd0, tbl[i].lst});
         end
         chk("tbl_done", {63'd0, done_o}, {63'd0, tbl[i].dn});
         chk("tbl_busy", {63'd0, busy_o}, {63'd0, tbl[i].bsy});
         chk("tbl_fill", {61'd0, fill_o}, 64'(tbl[i].fl));
      end
      start = 0; pe_valid = 0;

      // Backpressure: downstream stalled, only DEPTH words get in.
      got.delete();
      begin_xfer(8, 32'h21, 0);
      repeat (6) tick_feed(32'h28);
      chk("bp_fill", {61'd0, fill_o}, 64'd4);
      chk("bp_ready", {63'd0, pea_ready_o}, 64'd0);
      out_ready = 1;
      run_to_done("bp", 32'h28, 40);
      check_got("bp", 32'h21, 8);

      // Abort after three pushes with two buffered.
      got.delete();
      begin_xfer(8, 32'h31, 0);
      tick_feed(32'h38);
      tick_feed(32'h38);
      out_ready = 1;
      tick_feed(32'h38);
      chk("ab_fill_before", {61'd0, fill_o}, 64'd2);
      pe_valid = 0; out_ready = 0; abort = 1;
      begin
         int d0;
         d0 = done_seen;
         tick();
         abort = 0;
         chk("ab_fill", {61'd0, fill_o}, 64'd0);
         chk("ab_valid", {63'd0, out_valid_o}, 64'd0);
         chk("ab_busy", {63'd0, busy_o}, 64'd0);
         tick();
         chk("ab_no_done", 64'(done_seen - d0), 64'd0);
      end
      got.delete();
      begin_xfer(2, 32'h41, 1);
      run_to_done("ab2", 32'h42, 20);
      check_got("ab2", 32'h41, 2);

      // Full FIFO with a pop: no push that cycle, ready returns next cycle.
      got.delete();
      begin_xfer(6, 32'h51, 0);
      repeat (4) tick_feed(32'h56);
      chk("full_fill", {61'd0, fill_o}, 64'd4);
      chk("full_ready", {63'd0, pea_ready_o}, 64'd0);
      out_ready = 1;
      tick_feed(32'h56);
      chk("full_pop_fill", {61'd0, fill_o}, 64'd3);
      chk("full_pop_ready", {63'd0, pea_ready_o}, 64'd1);
      run_to_done("full", 32'h56, 30);
      check_got("full", 32'h51, 6);

      // Reset while draining.
      begin_xfer(2, 32'h61, 0);
      tick_feed(32'h62);
      tick_feed(32'h62);
      chk("dr_busy", {63'd0, busy_o}, 64'd1);
      chk("dr_ready", {63'd0, pea_ready_o}, 64'd0);
      rst = 1;
      tick();
      rst = 0;
      chk("dr_rst_valid", {63'd0, out_valid_o}, 64'd0);
      chk("dr_rst_data", {32'd0, out_data_o}, 64'd0);
      chk("dr_rst_last", {63'd0, out_last_o}, 64'd0);
      chk("dr_rst_fill", {61'd0, fill_o}, 64'd0);
      chk("dr_rst_flags", {61'd0, pea_ready_o, done_o, busy_o}, 64'd0);

      // Random transfers against the model.
      for (int t = 0; t < 40; t++) begin
         int n;
         bit fin;
         cfg_len = LW'($urandom_range(12, 0));
         start = 1;
         pe_valid = ($urandom_range(3, 0) != 0);
         pe_res = $urandom;
         out_ready = ($urandom_range(9, 0) < 7);
         tick();
         start = 0;
         n = 0;
         fin = (ph == P_IDLE);
         while (!fin && n < 300) begin
            if (!pe_valid || m_push) begin
               pe_valid = ($urandom_range(3, 0) != 0);
               pe_res = $urandom;
            end
            out_ready = ($urandom_range(9, 0) < 7);
            abort = ($urandom_range(199, 0) == 0);
            tick();
            abort = 0;
            n++;
            fin = (ph == P_IDLE);
         end
         chk("rnd_finished", {63'd0, fin}, 64'd1);
         pe_valid = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/s_pe_res_collector.md
# s_pe_res_collector

Streaming sink at the output edge of the streaming PE array: accepts result words from a selected PE output port (`pe_res_o`/`valid_o`), buffers them in a small FIFO and presents them on a valid/ready stream towards the output DMA. It drives the global `pea_ready` backpressure that every streaming PE samples, which stalls the whole array when the buffer is full. It counts accepted results against a programmed length, tags the final word and reports completion.

## Interface
- `N_BITS`, 32: data word width; matches `pea_pkg::N_BITS`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `LEN_W`, 16: width of the transfer-length counter.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `start_i`  in  1  starts a transfer; sampled only in IDLE.
- `abort_i`  in  1  aborts the transfer and flushes the FIFO; accepted in any state.
- `cfg_len_i`  in  LEN_W  number of results to collect; sampled with `start_i`.
- `pe_res_i`  in  N_BITS  result word from the PE output register.
- `pe_valid_i`  in  1  PE result valid.
- `pea_ready_o`  out  1  global array ready (backpressure) to all streaming PEs.
- `out_data_o`  out  N_BITS  FIFO head data.
- `out_valid_o`  out  1  FIFO head valid.
- `out_last_o`  out  1  head is the final word of the transfer.
- `out_ready_i`  in  1  downstream ready.
- `done_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  high in RUN and DRAIN.
- `fill_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `pea_ready_o`=0.
  - `start_i` with `cfg_len_i`≠0: latch the length, clear `acc_cnt`, go to RUN.
  - `start_i` with `cfg_len_i`=0: go to DONE; nothing is accepted.
- **RUN:**
  - `pea_ready_o` = (fill < DEPTH).
  - Push = `pe_valid_i` && `pea_ready_o`. The PE updates its output register on the same edge, so the word is consumed exactly once.
  - Each push increments `acc_cnt`. The push that makes `acc_cnt` equal the latched length writes `last`=1 into the entry and moves to DRAIN.
- **DRAIN:**
  - `pea_ready_o`=0; `pe_valid_i` is ignored.
  - The pop of the `last` entry moves to DONE.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
- **Pop:** pop = `out_valid_o` && `out_ready_i`. Pops are allowed in every state, including IDLE, for residue after an abort. The FIFO is flushed on abort, so there is no residue.
- **`abort_i`:** from any state goes to IDLE and empties the FIFO. No `done_o` is produced. `abort_i` has priority over `start_i` and over push/pop.
- **`busy_o`:** high in RUN and DRAIN.
- **Simultaneous push and pop:** occupancy unchanged.
- **Full FIFO with a pop in the same cycle:** no push, because `pea_ready_o` depends only on registered occupancy. This avoids a combinational `out_ready_i`→`pea_ready_o` path across the array.
- **Counter width:** `acc_cnt` is LEN_W bits and cannot overflow, since it stops at the length (≤ 2^LEN_W−1).

## Timing
- **Reset values:** state IDLE; FIFO empty; `pea_ready_o`=0, `out_valid_o`=0, `out_last_o`=0, `out_data_o`=0, `done_o`=0, `busy_o`=0, `fill_o`=0.
- **Input-to-output latency:** a word pushed at edge t appears on `out_data_o`/`out_valid_o` after edge t. There is no fall-through.
- **Start:** `start_i` at edge t → RUN from t; `pea_ready_o` is high in cycle t+1.
- **Backpressure:** `pea_ready_o` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop.
- **End of transfer:** the final pop at edge t → DONE in cycle t+1 → IDLE at t+2. A new `start_i` is honoured from cycle t+2.
- **`out_*` stability:** `out_data_o`/`out_last_o` are stable while `out_valid_o`=1 and `out_ready_i`=0.
- **Sustained throughput:** one word per cycle when `out_ready_i`=1 continuously.

## Structure
- **`pea_pkg`:** add `collector_state_t` (IDLE, RUN, DRAIN, DONE) and a `COLLECTOR_DEPTH` default constant.
- **Sub-module `s_res_fifo`:** synchronous FIFO, N_BITS+1 wide (data + last), with DEPTH entries, pointer wrap, a `flush_i` input and a fill count.
- **Top level:** holds the FSM, length latch, `acc_cnt` and backpressure logic.

## Test plan
- **Basic transfer:** `start_i` with `cfg_len_i`=4, PE supplies 0x11..0x14 back-to-back, `out_ready_i`=1 → output 0x11..0x14 in order. `out_last_o` is set only with 0x14. `done_o` pulses 1 cycle after the last pop, and `busy_o` falls with it.
- **Backpressure:** `cfg_len_i`=8, `out_ready_i`=0 → exactly 4 words accepted, then `pea_ready_o`=0 and the PE holds word 5. Releasing `out_ready_i` → all 8 words delivered, no duplicates or drops.
- **Zero length:** `start_i` with `cfg_len_i`=0 → `done_o` in the next cycle, `pea_ready_o` never asserted, no output.
- **Abort:** abort mid-transfer after 3 of 8 words with 2 buffered → next cycle in IDLE, `fill_o`=0, `out_valid_o`=0, no `done_o`. A new start with `cfg_len_i`=2 then completes normally.
- **Push/pop at full:** FIFO full and `out_ready_i`=1 → no push that cycle; `fill_o` goes 4→3 and `pea_ready_o` rises the next cycle.
- **Reset:** `rst_i` asserted in DRAIN → all outputs at reset values on the following cycle.
